// File: rtl/serial_addsub.sv
// serial_addsub: multi-cycle adder/subtractor that processes WIDTH-bit
// operands DIGIT bits per clock, least-significant digit first, through a
// single DIGIT-bit ripple slice with a registered carry between digits.
//
// Handshake: a start pulse is accepted on any rising edge where the block is
// IDLE or DONE; busy is high while digits are processed; done is a one-cycle
// pulse when sum/cout/ovf are updated. start is ignored while busy.
// FSM state is fully observable on the outputs: IDLE = !busy && !done,
// RUN = busy, DONE = done.
//
// WIDTH must be >= 2 and DIGIT must divide WIDTH exactly.
module serial_addsub #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int STEPS = WIDTH / DIGIT;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // Latched operands (B already inverted for subtract), shifted right one
    // digit per step so the active digit always sits at the bottom.
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    // Result digits enter at the top and move down; after STEPS shifts the
    // first digit has reached bit 0.
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] work_next;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic [DIGIT-1:0] a_dig;
    logic [DIGIT-1:0] b_dig;
    logic [DIGIT-1:0] s_dig;
    logic             c_dig;
    logic             msb_cin;
    logic             accept;
    logic             last;

    assign accept = start && ((state == IDLE) || (state == DONE));
    assign last   = (cnt == CW'(STEPS - 1));
    assign busy   = (state == RUN);
    assign done   = (state == DONE);

    // One DIGIT-bit ripple slice plus the shifted working register value.
    always_comb begin
        a_dig          = op_a[DIGIT-1:0];
        b_dig          = op_b[DIGIT-1:0];
        {c_dig, s_dig} = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry};
        // Carry into the slice's top bit, recovered from its sum bit; on the
        // last step this is the carry into the operand MSB.
        msb_cin        = a_dig[DIGIT-1] ^ b_dig[DIGIT-1] ^ s_dig[DIGIT-1];
        work_next      = (work >> DIGIT) | (WIDTH'(s_dig) << (WIDTH - DIGIT));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: RUN for exactly STEPS edges, DONE for one cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last) state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand latch, digit processing and result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_a  <= '0;
            op_b  <= '0;
            work  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else if (accept) begin
            op_a  <= a;
            op_b  <= b ^ {WIDTH{sub}};
            // Subtract is A + ~B + 1, so the carry-in is forced high.
            carry <= sub | cin;
            cnt   <= '0;
            work  <= '0;
        end else if (state == RUN) begin
            op_a  <= op_a >> DIGIT;
            op_b  <= op_b >> DIGIT;
            work  <= work_next;
            carry <= c_dig;
            cnt   <= cnt + CW'(1);
            if (last) begin
                sum  <= work_next;
                cout <= c_dig;
                ovf  <= msb_cin ^ c_dig;
            end
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub. Three instances cover the configurations
// of interest: 8-bit/1-bit digits, 8-bit/4-bit digits, 4-bit/2-bit digits.
module tb_serial_addsub;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       st [3];
    logic       sb [3];
    logic       ci [3];
    logic [7:0] aa [3];
    logic [7:0] bb [3];
    wire        busy_v [3];
    wire        done_v [3];
    wire        cout_v [3];
    wire        ovf_v  [3];
    wire  [7:0] sum_v  [3];
    wire  [3:0] sum4;

    int checks = 0;
    int errors = 0;

    assign sum_v[2] = {4'h0, sum4};

    always #5 clk = ~clk;

    serial_addsub #(.WIDTH(8), .DIGIT(1)) u_w8d1 (
        .clk(clk), .rst(rst), .start(st[0]), .sub(sb[0]), .a(aa[0]), .b(bb[0]),
        .cin(ci[0]), .busy(busy_v[0]), .done(done_v[0]), .sum(sum_v[0]),
        .cout(cout_v[0]), .ovf(ovf_v[0])
    );

    serial_addsub #(.WIDTH(8), .DIGIT(4)) u_w8d4 (
        .clk(clk), .rst(rst), .start(st[1]), .sub(sb[1]), .a(aa[1]), .b(bb[1]),
        .cin(ci[1]), .busy(busy_v[1]), .done(done_v[1]), .sum(sum_v[1]),
        .cout(cout_v[1]), .ovf(ovf_v[1])
    );

    serial_addsub #(.WIDTH(4), .DIGIT(2)) u_w4d2 (
        .clk(clk), .rst(rst), .start(st[2]), .sub(sb[2]), .a(aa[2][3:0]), .b(bb[2][3:0]),
        .cin(ci[2]), .busy(busy_v[2]), .done(done_v[2]), .sum(sum4),
        .cout(cout_v[2]), .ovf(ovf_v[2])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One operation on instance k: start pulse, bounded wait for done, then
    // result, latency and single-pulse checks. All sampling is at negedge.
    task automatic do_op(input int k, input logic s, input logic [7:0] av,
                         input logic [7:0] bv, input logic c,
                         input logic [7:0] e_sum, input logic e_cout,
                         input logic e_ovf, input int e_lat);
        int n;
        @(negedge clk);
        st[k] = 1'b1; sb[k] = s; aa[k] = av; bb[k] = bv; ci[k] = c;
        @(negedge clk);
        st[k] = 1'b0;
        aa[k] = 8'($urandom_range(0, 255));
        bb[k] = 8'($urandom_range(0, 255));
        chk("busy_after_start", {31'b0, busy_v[k]}, 32'd1);
        n = 1;
        while (!done_v[k] && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", {31'b0, done_v[k]}, 32'd1);
        chk("latency", n - 1, e_lat);
        chk("busy_with_done", {31'b0, busy_v[k]}, 32'd0);
        chk("sum", {24'b0, sum_v[k]}, {24'b0, e_sum});
        chk("cout", {31'b0, cout_v[k]}, {31'b0, e_cout});
        chk("ovf", {31'b0, ovf_v[k]}, {31'b0, e_ovf});
        @(negedge clk);
        chk("done_one_cycle", {31'b0, done_v[k]}, 32'd0);
    endtask

    logic [7:0] h_a   [3];
    logic [7:0] h_b   [3];
    logic       h_sub [3];
    logic       h_cin [3];
    logic [7:0] h_sum [3];
    logic       h_co  [3];
    logic       h_ov  [3];

    initial begin
        int npulse;
        int k;
        logic [4:0] r;
        logic [3:0] bx;
        logic       e_ov;

        for (int i = 0; i < 3; i++) begin
            st[i] = 1'b0; sb[i] = 1'b0; ci[i] = 1'b0; aa[i] = 8'h00; bb[i] = 8'h00;
        end

        // Reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", {31'b0, busy_v[0]}, 32'd0);
        chk("rst_done", {31'b0, done_v[0]}, 32'd0);
        chk("rst_sum", {24'b0, sum_v[0]}, 32'd0);

        // 8/1 add: 0x5A + 0x3C + 1 = 0x97, signed overflow
        do_op(0, 1'b0, 8'h5A, 8'h3C, 1'b1, 8'h97, 1'b0, 1'b1, 8);

        // Reset held two cycles in the middle of a run
        @(negedge clk);
        st[0] = 1'b1; sb[0] = 1'b0; aa[0] = 8'h11; bb[0] = 8'h22; ci[0] = 1'b0;
        @(negedge clk);
        st[0] = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("midrun_rst_busy", {31'b0, busy_v[0]}, 32'd0);
        chk("midrun_rst_done", {31'b0, done_v[0]}, 32'd0);
        chk("midrun_rst_sum", {24'b0, sum_v[0]}, 32'd0);
        chk("midrun_rst_cout", {31'b0, cout_v[0]}, 32'd0);
        chk("midrun_rst_ovf", {31'b0, ovf_v[0]}, 32'd0);
        rst = 1'b0;
        npulse = 0;
        repeat (12) begin
            @(negedge clk);
            if (done_v[0]) npulse++;
        end
        chk("no_done_after_abort", npulse, 0);

        // 8/1 add wrap: 0xFF + 0x01 = 0x100
        do_op(0, 1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 8);
        // 8/4 subtract: cin must be ignored
        do_op(1, 1'b1, 8'h10, 8'h20, 1'b0, 8'hF0, 1'b0, 1'b0, 2);
        do_op(1, 1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1, 2);
        do_op(1, 1'b1, 8'h33, 8'h33, 1'b0, 8'h00, 1'b1, 1'b0, 2);

        // Back-to-back with start held high: accepting edges every 9 cycles,
        // inputs scrambled while running.
        h_sub[0] = 1'b0; h_a[0] = 8'h12; h_b[0] = 8'h34; h_cin[0] = 1'b0;
        h_sum[0] = 8'h46; h_co[0] = 1'b0; h_ov[0] = 1'b0;
        h_sub[1] = 1'b1; h_a[1] = 8'h05; h_b[1] = 8'h07; h_cin[1] = 1'b1;
        h_sum[1] = 8'hFE; h_co[1] = 1'b0; h_ov[1] = 1'b0;
        h_sub[2] = 1'b0; h_a[2] = 8'h7F; h_b[2] = 8'h7F; h_cin[2] = 1'b1;
        h_sum[2] = 8'hFF; h_co[2] = 1'b0; h_ov[2] = 1'b1;
        @(negedge clk);
        npulse = 0;
        for (int t = 0; t <= 27; t++) begin
            k = t / 9;
            if (t > 0 && t % 9 == 0) begin
                npulse++;
                chk("b2b_done", {31'b0, done_v[0]}, 32'd1);
                chk("b2b_sum", {24'b0, sum_v[0]}, {24'b0, h_sum[k-1]});
                chk("b2b_cout", {31'b0, cout_v[0]}, {31'b0, h_co[k-1]});
                chk("b2b_ovf", {31'b0, ovf_v[0]}, {31'b0, h_ov[k-1]});
            end else if (t > 0) begin
                chk("b2b_busy", {31'b0, busy_v[0]}, 32'd1);
                chk("b2b_no_done", {31'b0, done_v[0]}, 32'd0);
                if (t > 9) chk("b2b_sum_hold", {24'b0, sum_v[0]}, {24'b0, h_sum[k-1]});
            end
            if (t % 9 == 0 && k < 3) begin
                st[0] = 1'b1; sb[0] = h_sub[k]; aa[0] = h_a[k]; bb[0] = h_b[k]; ci[0] = h_cin[k];
            end else begin
                st[0] = (k < 3);
                sb[0] = ~sb[0];
                aa[0] = 8'($urandom_range(0, 255));
                bb[0] = 8'($urandom_range(0, 255));
                ci[0] = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
        end
        chk("b2b_result_count", npulse, 3);
        chk("b2b_idle", {31'b0, done_v[0] | busy_v[0]}, 32'd0);

        // 4/2 exhaustive against an arithmetic reference
        for (int s = 0; s < 2; s++) begin
            for (int c = 0; c < 2; c++) begin
                for (int x = 0; x < 16; x++) begin
                    for (int y = 0; y < 16; y++) begin
                        bx = (s != 0) ? ~4'(y) : 4'(y);
                        r = 5'(x) + 5'(bx) + 5'((s != 0) ? 1 : c);
                        e_ov = (x[3] == bx[3]) && (r[3] != x[3]);
                        do_op(2, 1'(s), 8'(x), 8'(y), 1'(c), {4'h0, r[3:0]}, r[4], e_ov, 2);
                    end
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
